token_source_actor: RTL

TOKEN_SOURCE_ACTOR -- requirements
Module: token_source_actor

---
 rtl/token_actor_pkg.sv | 20 ++
 rtl/token_source_actor_if.sv | 25 ++
 rtl/token_rom.sv | 18 +
 rtl/token_source_actor.sv | 101 ++++++++++
 4 files changed

// File: rtl/token_actor_pkg.sv
// Shared types and helpers for the token source actor.
//   state_t    : actor FSM states
//   COUNT_ONE  : tokens carried per transfer
//   idx_width(): table index width for a given depth (never below 1 bit)
package token_actor_pkg;

  typedef enum logic [1:0] {
    KICK     = 2'd0,
    WAIT_RDY = 2'd1,
    SEND     = 2'd2,
    FINISHED = 2'd3
  } state_t;

  localparam logic [15:0] COUNT_ONE = 16'h0001;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth <= 32'd1) ? 32'd1 : 32'($clog2(depth));
  endfunction

endpackage

// File: rtl/token_source_actor_if.sv
// Token handshake bundle between a producer (master) and a consumer (slave).
//   src_RDY   : consumer can accept a token
//   src_ACK   : consumer has taken the offered token
//   src_SEND  : token offered
//   src_DATA  : token value, valid while src_SEND=1
//   src_COUNT : tokens per transfer
interface token_source_actor_if #(
  parameter int unsigned DATA_W = 8
);
  logic              src_RDY;
  logic              src_ACK;
  logic              src_SEND;
  logic [DATA_W-1:0] src_DATA;
  logic [15:0]       src_COUNT;

  modport master (
    input  src_RDY, src_ACK,
    output src_SEND, src_DATA, src_COUNT
  );

  modport slave (
    output src_RDY, src_ACK,
    input  src_SEND, src_DATA, src_COUNT
  );
endinterface

// File: rtl/token_rom.sv
// Read-only token table, combinational read from the packed INIT constant.
//   addr : entry index (entry 0 lives in the INIT LSBs)
//   data : entry value, zero for addresses at or beyond DEPTH
module token_rom
  import token_actor_pkg::*;
#(
  parameter int unsigned               DATA_W = 8,
  parameter int unsigned               DEPTH  = 5,
  parameter logic [DEPTH*DATA_W-1:0]   INIT   = (DEPTH*DATA_W)'(40'h00_00_18_06_15)
) (
  input  logic [idx_width(DEPTH)-1:0] addr,
  output logic [DATA_W-1:0]           data
);

  // Guard covers non-power-of-two depths where addr can encode unused entries.
  assign data = (32'(addr) < DEPTH) ? INIT[32'(addr)*DATA_W +: DATA_W] : '0;

endmodule

// File: rtl/token_source_actor.sv
// Token source actor: replays a constant table as tokens over a RDY/ACK
// handshake, one pass or looping.
//   CLK, RESET : clock, asynchronous active-high reset
//   src        : master side of the token handshake
//   sent_cnt   : tokens acknowledged since reset (wraps)
//   done       : final token of a non-looping pass acknowledged
module token_source_actor
  import token_actor_pkg::*;
#(
  parameter int unsigned             DATA_W = 8,
  parameter int unsigned             DEPTH  = 5,
  parameter int unsigned             LOOP   = 0,
  parameter logic [DEPTH*DATA_W-1:0] INIT   = (DEPTH*DATA_W)'(40'h00_00_18_06_15)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  token_source_actor_if.master src,
  output logic [15:0]          sent_cnt,
  output logic                 done
);

  localparam int unsigned        IDX_W    = idx_width(DEPTH);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [DATA_W-1:0]   rom_data;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic                send_q, send_nxt;
  logic [15:0]         cnt_nxt;
  logic                done_nxt;
  logic                last_c;
  logic                take_c;

  token_rom #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .INIT   (INIT)
  ) u_rom (
    .addr (idx),
    .data (rom_data)
  );

  assign last_c = (idx == IDX_LAST);
  // An ACK only counts while an offer is actually outstanding.
  assign take_c = (state == SEND) && src.src_ACK;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= KICK;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      KICK:     state_nxt = WAIT_RDY;
      WAIT_RDY: if (src.src_RDY) state_nxt = SEND;
      SEND:     if (src.src_ACK) state_nxt = (last_c && (LOOP == 0)) ? FINISHED : WAIT_RDY;
      FINISHED: state_nxt = FINISHED;
      default:  state_nxt = KICK;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    idx_nxt  = idx;
    data_nxt = data_q;
    cnt_nxt  = sent_cnt;
    if ((state == WAIT_RDY) && src.src_RDY) data_nxt = rom_data;
    if (take_c) begin
      cnt_nxt = sent_cnt + 16'd1;
      idx_nxt = last_c ? '0 : idx + IDX_W'(1);
    end
    send_nxt = (state_nxt == SEND);
    done_nxt = (state_nxt == FINISHED);
  end

  // Registered outputs and datapath
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx      <= '0;
      data_q   <= '0;
      send_q   <= 1'b0;
      sent_cnt <= 16'd0;
      done     <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      data_q   <= data_nxt;
      send_q   <= send_nxt;
      sent_cnt <= cnt_nxt;
      done     <= done_nxt;
    end
  end

  assign src.src_SEND  = send_q;
  assign src.src_DATA  = data_q;
  assign src.src_COUNT = COUNT_ONE;

endmodule
